mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Time-shares the single external SRAM port between instruction fetch (IF) and data memory access (MEM).
- Sequences the SRAM control pins and produces the registered inst_read_done and mem_done flags that the pipeline stall logic consumes.
- Data accesses take priority over fetch.
- Sits between the IF/MEM stages and the board SRAM pins.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM/word data width.
- ACC_CYCLES, 2, cycles OE_n/WE_n are held low per access (≥1).

Ports:
- clk in 1: system clock; all state updates on rising edge.
- rst in 1: asynchronous active-low reset.
- step in 1: pipeline-advance strobe (= !hold); sampled on clk only.
- if_req in 1: fetch request, level.
- if_addr in ADDR_W: fetch address.
- mem_rd in 1: data read request, level.
- mem_wr in 1: data write request, level; mem_rd && mem_wr is illegal.
- mem_addr in ADDR_W: data address.
- mem_wdata in DATA_W: store data.
- inst out DATA_W: fetched word.
- inst_read_done out 1: fetch word valid.
- mem_rdata out DATA_W: load result.
- mem_done out 1: data op complete.
- ram_addr out ADDR_W: SRAM address.
- ram_dout out DATA_W: SRAM write data.
- ram_doe out 1: 1 = drive ram data bus.
- ram_din in DATA_W: SRAM read data.
- ram_ce_n out 1: SRAM chip enable, active low.
- ram_oe_n out 1: SRAM output enable, active low.
- ram_we_n out 1: SRAM write enable, active low.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; inst=0, mem_rdata=0, inst_read_done=0, mem_done=0.
  - ram_ce_n=1, ram_oe_n=1, ram_we_n=1, ram_doe=0, ram_addr=0, ram_dout=0.
  - Reset mid-access aborts immediately; no done flag is set.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, SETUP, ACCESS, FINISH.
- IDLE selection, first match wins:
  - (mem_rd|mem_wr) && !mem_done -> data op.
  - if_req && !inst_read_done -> fetch.
  - Otherwise stay IDLE, ram_ce_n=1.
- On selection: latch op type and address into ram_addr; for writes, latch mem_wdata into ram_dout. Go to SETUP.
- SETUP, 1 cycle:
  - ram_ce_n=0, ram_oe_n=1, ram_we_n=1.
  - ram_doe=1 for writes (data setup before WE_n falls).
  - Go to ACCESS with counter=ACC_CYCLES-1.
- ACCESS, ACC_CYCLES cycles:
  - Reads: ram_oe_n=0. Writes: ram_we_n=0, ram_doe=1.
  - Counter decrements each cycle; at 0, go to FINISH.
  - Reads capture ram_din into the target register (inst or mem_rdata) on the last ACCESS edge.
- FINISH, 1 cycle:
  - ram_oe_n=1, ram_we_n=1; ram_ce_n=0 and ram_doe held for write hold time.
  - Set the target done flag; return to IDLE.
- Latency: request seen in IDLE -> done flag high 3+ACC_CYCLES cycles later (5 at default).
- Back-to-back: IDLE may select the next op in the cycle after FINISH. No bus turnaround beyond FINISH.
- Done flags are sticky. Both flags clear on a clk edge with step=1. Clear and set cannot coincide, because step=1 implies no op is pending.
- inst and mem_rdata hold their value until overwritten by the next completed access of the same kind.
- Requests drop mid-access: the access still completes; the done flag is still set and cleared by the next step.
- Requester inputs are ignored outside IDLE; the latched address is used throughout.
- mem_rd && mem_wr together: treated as a write (defined, not supported).

Test Plan:
1. Reset then fetch:
   - Stimulus: rst low 3 cycles; if_req=1, if_addr=0x00010, SRAM model returns 0x4A3C.
   - Required: ram_oe_n low exactly 2 cycles; inst_read_done=1 at cycle 5 with inst=0x4A3C; stays 1 until step=1, then 0 next edge.
2. Collision:
   - Stimulus: mem_rd=1 at addr 0x0BF00 and if_req=1 at 0x00011 in the same IDLE cycle.
   - Required: data read serviced first, mem_done at cycle 5; fetch starts cycle 6, inst_read_done at cycle 10; ram_ce_n never glitches high between them.
3. Store timing:
   - Stimulus: mem_wr=1, addr 0x0BF01, wdata 0x00FF.
   - Required: ram_doe=1 from SETUP through FINISH; ram_we_n low exactly ACC_CYCLES cycles and only while ram_doe=1; model word 0x0BF01=0x00FF; mem_done=1 at cycle 5.
4. Reset mid-access:
   - Stimulus: fetch in progress; assert rst during ACCESS.
   - Required: all SRAM controls inactive immediately (asynchronously); inst_read_done=0; after release, re-request completes normally.
5. ACC_CYCLES=4 variant:
   - Stimulus: fetch with ACC_CYCLES=4.
   - Required: done at cycle 7; ram_oe_n low exactly 4 cycles.
6. Sticky done with no step:
   - Stimulus: mem_done=1, step held 0 for 10 cycles, mem_rd still high.
   - Required: no new SRAM access (ram_ce_n=1); mem_rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request/response and SRAM pin bundle for mem_arbiter.
// slave is the arbiter's view; master is the pipeline/board side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              step;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] inst;
  logic              inst_read_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_doe;
  logic [DATA_W-1:0] ram_din;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;

  modport slave (
    input  step, if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_din,
    output inst, inst_read_done, mem_rdata, mem_done,
           ram_addr, ram_dout, ram_doe, ram_ce_n, ram_oe_n, ram_we_n
  );

  modport master (
    output step, if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_din,
    input  inst, inst_read_done, mem_rdata, mem_done,
           ram_addr, ram_dout, ram_doe, ram_ce_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one asynchronous SRAM port between instruction fetch and data access.
// Data wins over fetch; every output is a register loaded from the next-state decode.
module mem_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int ACC_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int               CNT_W    = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, FINISH} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr, op_data;
  logic              sel_data, sel_inst, acc_last, wr_nx;

  logic [DATA_W-1:0] inst_q, inst_nx, rdata_q, rdata_nx, dout_q, dout_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic              idone_q, idone_nx, mdone_q, mdone_nx;
  logic              ce_n_q, ce_n_nx, oe_n_q, oe_n_nx, we_n_q, we_n_nx, doe_q, doe_nx;

  assign sel_data = (bus.mem_rd | bus.mem_wr) & ~mdone_q;
  assign sel_inst = bus.if_req & ~idone_q;
  assign acc_last = (cnt == '0);
  assign wr_nx    = (state == IDLE) ? (sel_data & bus.mem_wr) : op_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      op_data <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (sel_data) begin
            op_data <= 1'b1;
            op_wr   <= bus.mem_wr;
          end else if (sel_inst) begin
            op_data <= 1'b0;
            op_wr   <= 1'b0;
          end
        end
        SETUP:   cnt <= CNT_LOAD;
        ACCESS:  if (!acc_last) cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sel_data || sel_inst) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (acc_last) state_nx = FINISH;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ce_n_nx  = 1'b1;
    oe_n_nx  = 1'b1;
    we_n_nx  = 1'b1;
    doe_nx   = 1'b0;
    addr_nx  = addr_q;
    dout_nx  = dout_q;
    inst_nx  = inst_q;
    rdata_nx = rdata_q;
    idone_nx = idone_q & ~bus.step;
    mdone_nx = mdone_q & ~bus.step;
    unique case (state_nx)
      SETUP: begin
        ce_n_nx = 1'b0;
        doe_nx  = wr_nx;
      end
      ACCESS: begin
        ce_n_nx = 1'b0;
        oe_n_nx = wr_nx;
        we_n_nx = ~wr_nx;
        doe_nx  = wr_nx;
      end
      FINISH: begin
        ce_n_nx = 1'b0;
        doe_nx  = op_wr;
      end
      // CE_n stays low through the IDLE cycle after FINISH so a back-to-back op never pulses it.
      default: ce_n_nx = (state != FINISH);
    endcase
    if (state == IDLE && sel_data) begin
      addr_nx = bus.mem_addr;
      if (bus.mem_wr) dout_nx = bus.mem_wdata;
    end else if (state == IDLE && sel_inst) begin
      addr_nx = bus.if_addr;
    end
    if (state == ACCESS && acc_last && !op_wr) begin
      if (op_data) rdata_nx = bus.ram_din;
      else         inst_nx  = bus.ram_din;
    end
    if (state == FINISH) begin
      if (op_data) mdone_nx = 1'b1;
      else         idone_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q  <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
      addr_q  <= '0;
      idone_q <= 1'b0;
      mdone_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
    end else begin
      inst_q  <= inst_nx;
      rdata_q <= rdata_nx;
      dout_q  <= dout_nx;
      addr_q  <= addr_nx;
      idone_q <= idone_nx;
      mdone_q <= mdone_nx;
      ce_n_q  <= ce_n_nx;
      oe_n_q  <= oe_n_nx;
      we_n_q  <= we_n_nx;
      doe_q   <= doe_nx;
    end
  end

  assign bus.inst           = inst_q;
  assign bus.mem_rdata      = rdata_q;
  assign bus.inst_read_done = idone_q;
  assign bus.mem_done       = mdone_q;
  assign bus.ram_addr       = addr_q;
  assign bus.ram_dout       = dout_q;
  assign bus.ram_doe        = doe_q;
  assign bus.ram_ce_n       = ce_n_q;
  assign bus.ram_oe_n       = oe_n_q;
  assign bus.ram_we_n       = we_n_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random pipeline traffic checked
// every cycle against a transaction-level timing model and an SRAM word model.
module tb_mem_arbiter;
  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int ACC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b  ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b4 ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(ACC)) dut  (.clk(clk), .rst(rst), .bus(b));
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(4))   dut4 (.clk(clk), .rst(rst), .bus(b4));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Board SRAM (driven by DUT pins) and the model's own memory image.
  logic [DW-1:0] sram    [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction
  function automatic logic [DW-1:0] env_rd(input logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : dflt(a);
  endfunction
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  always @(negedge clk) begin
    if (!b.ram_ce_n && !b.ram_we_n && b.ram_doe) sram[b.ram_addr] = b.ram_dout;
    b.ram_din = env_rd(b.ram_addr);
  end

  // Transaction model: an op selected at edge t drives SETUP, ACC access cycles, FINISH,
  // then its done flag appears at edge t+ACC+2, when the port is free again.
  bit            m_busy, m_hold, m_wr, m_data;
  int            m_age;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout, e_inst, e_rdata;
  bit            e_idone, e_mdone;

  task automatic model_reset();
    m_busy = 0; m_hold = 0; m_wr = 0; m_data = 0; m_age = 0;
    m_addr = '0; m_dout = '0; e_inst = '0; e_rdata = '0;
    e_idone = 0; e_mdone = 0;
  endtask

  task automatic model_edge();
    bit sel_d, sel_i;
    if (!rst) begin
      model_reset();
      return;
    end
    m_hold = 0;
    if (m_busy) begin
      m_age++;
      if (b.step) begin e_idone = 0; e_mdone = 0; end
      if (m_age == ACC + 1 && !m_wr) begin
        if (m_data) e_rdata = ref_rd(m_addr);
        else        e_inst  = ref_rd(m_addr);
      end
      if (m_age == ACC + 2) begin
        if (m_wr) begin
          ref_mem[m_addr] = m_dout;
          check("sram_word", 32'(env_rd(m_addr)), 32'(m_dout));
        end
        if (m_data) e_mdone = 1;
        else        e_idone = 1;
        m_busy = 0;
        m_hold = 1;
      end
    end else begin
      sel_d = (b.mem_rd || b.mem_wr) && !e_mdone;
      sel_i = b.if_req && !e_idone;
      if (b.step) begin e_idone = 0; e_mdone = 0; end
      if (sel_d || sel_i) begin
        m_busy = 1;
        m_age  = 0;
        m_data = sel_d;
        m_wr   = sel_d && b.mem_wr;
        m_addr = sel_d ? b.mem_addr : b.if_addr;
        if (m_wr) m_dout = b.mem_wdata;
      end
    end
  endtask

  task automatic compare_outputs();
    bit acc;
    acc = m_busy && m_age >= 1 && m_age <= ACC;
    check("ce_n",      32'(b.ram_ce_n),       32'(!(m_busy || m_hold)));
    check("oe_n",      32'(b.ram_oe_n),       32'(!(acc && !m_wr)));
    check("we_n",      32'(b.ram_we_n),       32'(!(acc && m_wr)));
    check("doe",       32'(b.ram_doe),        32'(m_busy && m_wr));
    check("ram_addr",  32'(b.ram_addr),       32'(m_addr));
    check("ram_dout",  32'(b.ram_dout),       32'(m_dout));
    check("idone",     32'(b.inst_read_done), 32'(e_idone));
    check("mdone",     32'(b.mem_done),       32'(e_mdone));
    check("inst",      32'(b.inst),           32'(e_inst));
    check("mem_rdata", 32'(b.mem_rdata),      32'(e_rdata));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic run_op(input bit is_data, input int max, output int lat, output int n_oe,
                        output int n_we, output int n_ce_hi, output int n_we_bad, output int n_doe);
    lat = -1; n_oe = 0; n_we = 0; n_ce_hi = 0; n_we_bad = 0; n_doe = 0;
    for (int k = 1; k <= max && lat < 0; k++) begin
      cycle();
      if (!b.ram_oe_n) n_oe++;
      if (!b.ram_we_n) begin
        n_we++;
        if (!b.ram_doe) n_we_bad++;
      end
      if (b.ram_ce_n) n_ce_hi++;
      if (b.ram_doe) n_doe++;
      if (is_data ? b.mem_done : b.inst_read_done) lat = k;
    end
  endtask

  task automatic step_clear();
    b.step = 1; b.if_req = 0; b.mem_rd = 0; b.mem_wr = 0;
    cycle();
    b.step = 0;
  endtask

  initial begin
    int lat, lat2, n_oe, n_we, n_ce_hi, n_ce_hi2, n_we_bad, n_doe, n_ce_lo, n_oe4;
    bit stepped;
    rst = 0;
    b.step = 0; b.if_req = 0; b.if_addr = '0; b.mem_rd = 0; b.mem_wr = 0;
    b.mem_addr = '0; b.mem_wdata = '0;
    b4.step = 0; b4.if_req = 0; b4.if_addr = '0; b4.mem_rd = 0; b4.mem_wr = 0;
    b4.mem_addr = '0; b4.mem_wdata = '0; b4.ram_din = '0;
    sram[18'h00010] = 16'h4A3C; ref_mem[18'h00010] = 16'h4A3C;
    sram[18'h0BF00] = 16'hC0DE; ref_mem[18'h0BF00] = 16'hC0DE;
    sram[18'h00011] = 16'h1111; ref_mem[18'h00011] = 16'h1111;
    sram[18'h00020] = 16'h2222; ref_mem[18'h00020] = 16'h2222;
    sram[18'h0BF02] = 16'hBEEF; ref_mem[18'h0BF02] = 16'hBEEF;

    // Reset, then a single fetch.
    repeat (3) cycle();
    check("rst_ce_n", 32'(b.ram_ce_n), 32'd1);
    check("rst_inst", 32'(b.inst), 32'd0);
    rst = 1;
    b.if_req = 1; b.if_addr = 18'h00010;
    run_op(0, 20, lat, n_oe, n_we, n_ce_hi, n_we_bad, n_doe);
    check("t1_latency", 32'(lat), 32'd5);
    check("t1_oe_cycles", 32'(n_oe), 32'd2);
    check("t1_inst", 32'(b.inst), 32'h4A3C);
    repeat (3) cycle();
    check("t1_sticky", 32'(b.inst_read_done), 32'd1);
    step_clear();
    check("t1_cleared", 32'(b.inst_read_done), 32'd0);

    // Data read and fetch collide; data first, port held through both.
    b.mem_rd = 1; b.mem_addr = 18'h0BF00; b.if_req = 1; b.if_addr = 18'h00011;
    run_op(1, 20, lat, n_oe, n_we, n_ce_hi, n_we_bad, n_doe);
    check("t2_mem_latency", 32'(lat), 32'd5);
    check("t2_inst_pending", 32'(b.inst_read_done), 32'd0);
    run_op(0, 20, lat2, n_oe, n_we, n_ce_hi2, n_we_bad, n_doe);
    check("t2_inst_latency", 32'(lat + lat2), 32'd10);
    check("t2_ce_glitch", 32'(n_ce_hi + n_ce_hi2), 32'd0);
    check("t2_rdata", 32'(b.mem_rdata), 32'hC0DE);
    check("t2_inst", 32'(b.inst), 32'h1111);
    step_clear();

    // Store timing.
    b.mem_wr = 1; b.mem_addr = 18'h0BF01; b.mem_wdata = 16'h00FF;
    run_op(1, 20, lat, n_oe, n_we, n_ce_hi, n_we_bad, n_doe);
    check("t3_latency", 32'(lat), 32'd5);
    check("t3_we_cycles", 32'(n_we), 32'd2);
    check("t3_we_without_doe", 32'(n_we_bad), 32'd0);
    check("t3_doe_cycles", 32'(n_doe), 32'd4);
    check("t3_oe_cycles", 32'(n_oe), 32'd0);
    check("t3_word", 32'(env_rd(18'h0BF01)), 32'h00FF);
    step_clear();

    // Sticky done with step low: no new access.
    b.mem_rd = 1; b.mem_addr = 18'h0BF02;
    run_op(1, 20, lat, n_oe, n_we, n_ce_hi, n_we_bad, n_doe);
    check("t6_latency", 32'(lat), 32'd5);
    n_ce_lo = 0;
    repeat (10) begin
      cycle();
      if (!b.ram_ce_n) n_ce_lo++;
    end
    check("t6_no_access", 32'(n_ce_lo), 32'd0);
    check("t6_rdata", 32'(b.mem_rdata), 32'hBEEF);
    check("t6_sticky", 32'(b.mem_done), 32'd1);
    step_clear();

    // Reset during ACCESS.
    b.if_req = 1; b.if_addr = 18'h00020;
    cycle(); cycle();
    check("t4_in_access", 32'(b.ram_oe_n), 32'd0);
    #2 rst = 0;
    #1;
    check("t4_ce_n", 32'(b.ram_ce_n), 32'd1);
    check("t4_oe_n", 32'(b.ram_oe_n), 32'd1);
    check("t4_doe", 32'(b.ram_doe), 32'd0);
    check("t4_idone", 32'(b.inst_read_done), 32'd0);
    model_reset();
    cycle();
    rst = 1;
    run_op(0, 20, lat, n_oe, n_we, n_ce_hi, n_we_bad, n_doe);
    check("t4_relatency", 32'(lat), 32'd5);
    check("t4_inst", 32'(b.inst), 32'h2222);
    step_clear();

    // Four-cycle access variant.
    b4.ram_din = 16'h1234; b4.if_addr = 18'h00005; b4.if_req = 1;
    lat = -1; n_oe4 = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      cycle();
      if (!b4.ram_oe_n) n_oe4++;
      if (b4.inst_read_done) lat = k;
    end
    check("t5_latency", 32'(lat), 32'd7);
    check("t5_oe_cycles", 32'(n_oe4), 32'd4);
    check("t5_inst", 32'(b4.inst), 32'h1234);
    b4.if_req = 0; b4.step = 1;
    cycle();
    b4.step = 0;
    check("t5_cleared", 32'(b4.inst_read_done), 32'd0);

    // Random pipeline traffic: requests held until a legal step, occasional drops.
    stepped = 1;
    for (int i = 0; i < 1500; i++) begin
      if (stepped) begin
        b.if_req    = ($urandom_range(0, 3) != 0);
        b.if_addr   = 18'($urandom_range(0, 63));
        b.mem_addr  = 18'($urandom_range(0, 63));
        b.mem_wdata = 16'($urandom);
        case ($urandom_range(0, 2))
          0:       begin b.mem_rd = 0; b.mem_wr = 0; end
          1:       begin b.mem_rd = 1; b.mem_wr = 0; end
          default: begin b.mem_rd = 0; b.mem_wr = 1; end
        endcase
      end else if ($urandom_range(0, 19) == 0) begin
        b.if_req = 0; b.mem_rd = 0; b.mem_wr = 0;
      end
      b.step = !m_busy && (!b.if_req || e_idone) && (!(b.mem_rd || b.mem_wr) || e_mdone)
               && ($urandom_range(0, 3) != 0);
      stepped = b.step;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
